branch_predict_unit: RTL and testbench

- Parametrised successor to the combinational branch block in the execute stage.
- Resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and JAL/JALR with a one-cycle registered result.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters, read by fetch for prediction and trained at resolve.
- Flags mispredicts, misaligned targets and illegal funct3 to the pipeline controller.

---
 rtl/branch_predict_unit.sv | 180 ++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch/jump resolve unit with a one-cycle registered result and a bimodal BHT of 2-bit counters.
// Optional macro BRANCH_RVC_EN adds is_compressed (+2 sequential PC, 2-byte alignment check).
module branch_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [1:0]      kind,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] register_source_1,
  input  logic [XLEN-1:0] register_source_2,
  input  logic [XLEN-1:0] program_counter,
  input  logic [XLEN-1:0] offset,
  input  logic            predicted_taken,
`ifdef BRANCH_RVC_EN
  input  logic            is_compressed,
`endif
  input  logic [XLEN-1:0] predict_pc,
  output logic            predict_taken,
  output logic            out_valid,
  output logic [XLEN-1:0] new_program_counter,
  output logic [XLEN-1:0] link_address,
  output logic            taken,
  output logic            mispredict,
  output logic            misaligned,
  output logic            illegal
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;

  logic [1:0]       bht_reg [BHT_DEPTH];
  logic [IDX_W-1:0] predict_idx;
  logic [IDX_W-1:0] train_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  logic            capture;
  logic            train;
  logic            cond;
  logic            illegal_next;
  logic            taken_next;
  logic            misaligned_next;
  logic            mispredict_next;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] npc_next;

  logic            out_valid_reg;
  logic [XLEN-1:0] npc_reg;
  logic [XLEN-1:0] link_reg;
  logic            taken_reg;
  logic            mispredict_reg;
  logic            misaligned_reg;
  logic            illegal_reg;

  // Bits outside the BHT index and the JALR-cleared bit are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{predict_pc[XLEN-1:IDX_W+2], predict_pc[1:0], jalr_sum[0]};

  assign predict_idx   = predict_pc[IDX_W+1:2];
  assign train_idx     = program_counter[IDX_W+1:2];
  // Plain array read: a same-cycle write is only visible after the edge.
  assign predict_taken = bht_reg[predict_idx][1];

  assign capture = in_valid & ~flush;

  always_comb begin
    cond         = 1'b0;
    illegal_next = 1'b0;
    case (funct3)
      3'b000:  cond = (register_source_1 == register_source_2);
      3'b001:  cond = (register_source_1 != register_source_2);
      3'b100:  cond = ($signed(register_source_1) <  $signed(register_source_2));
      3'b101:  cond = ($signed(register_source_1) >= $signed(register_source_2));
      3'b110:  cond = (register_source_1 <  register_source_2);
      3'b111:  cond = (register_source_1 >= register_source_2);
      default: illegal_next = (kind == KIND_BRANCH);
    endcase
  end

  always_comb begin
`ifdef BRANCH_RVC_EN
    seq_pc = program_counter + (is_compressed ? XLEN'(2) : XLEN'(4));
`else
    seq_pc = program_counter + XLEN'(4);
`endif
    jalr_sum = register_source_1 + offset;
    if (kind == KIND_JALR) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      target = program_counter + offset;
    end

    case (kind)
      KIND_BRANCH: taken_next = cond & ~illegal_next;
      KIND_JAL,
      KIND_JALR:   taken_next = 1'b1;
      default:     taken_next = 1'b0;
    endcase

    npc_next = taken_next ? target : seq_pc;
`ifdef BRANCH_RVC_EN
    misaligned_next = taken_next & target[0];
`else
    misaligned_next = taken_next & (target[1:0] != 2'b00);
`endif

    // No target prediction exists, so every JALR redirects.
    if (illegal_next) begin
      mispredict_next = 1'b0;
    end else if (kind == KIND_JALR) begin
      mispredict_next = 1'b1;
    end else begin
      mispredict_next = (taken_next != predicted_taken);
    end
  end

  assign train = capture & (kind == KIND_BRANCH) & ~illegal_next;

  always_comb begin
    ctr_cur  = bht_reg[train_idx];
    ctr_next = ctr_cur;
    if (taken_next) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_reg[i] <= BHT_INIT;
      end
    end else if (train) begin
      bht_reg[train_idx] <= ctr_next;
    end
  end

  // Data outputs keep their last captured values while out_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      npc_reg        <= '0;
      link_reg       <= '0;
      taken_reg      <= 1'b0;
      mispredict_reg <= 1'b0;
      misaligned_reg <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      out_valid_reg <= capture;
      if (capture) begin
        npc_reg        <= npc_next;
        link_reg       <= seq_pc;
        taken_reg      <= taken_next;
        mispredict_reg <= mispredict_next;
        misaligned_reg <= misaligned_next;
        illegal_reg    <= illegal_next;
      end
    end
  end

  assign out_valid           = out_valid_reg;
  assign new_program_counter = npc_reg;
  assign link_address        = link_reg;
  assign taken               = taken_reg;
  assign mispredict          = mispredict_reg;
  assign misaligned          = misaligned_reg;
  assign illegal             = illegal_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default parameters, XLEN=32, 16 BHT entries).
module tb_branch_predict_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            flush;
  logic [1:0]      kind;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] offset;
  logic            predicted_taken;
  logic            is_compressed;
  logic [XLEN-1:0] predict_pc;
  logic            predict_taken;
  logic            out_valid;
  logic [XLEN-1:0] new_program_counter;
  logic [XLEN-1:0] link_address;
  logic            taken;
  logic            mispredict;
  logic            misaligned;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .flush               (flush),
    .kind                (kind),
    .funct3              (funct3),
    .register_source_1   (rs1),
    .register_source_2   (rs2),
    .program_counter     (pc),
    .offset              (offset),
    .predicted_taken     (predicted_taken),
`ifdef BRANCH_RVC_EN
    .is_compressed       (is_compressed),
`endif
    .predict_pc          (predict_pc),
    .predict_taken       (predict_taken),
    .out_valid           (out_valid),
    .new_program_counter (new_program_counter),
    .link_address        (link_address),
    .taken               (taken),
    .mispredict          (mispredict),
    .misaligned          (misaligned),
    .illegal             (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] o,
                        input logic pt);
    in_valid = 1'b1; flush = 1'b0; kind = k; funct3 = f3;
    rs1 = a; rs2 = b; pc = p; offset = o; predicted_taken = pt;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; kind = 2'b11;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (new_program_counter !== 32'h0) begin errors++; $display("FAIL reset_npc got %h want 0", new_program_counter); end
    checks++; if (link_address !== 32'h0) begin errors++; $display("FAIL reset_link got %h want 0", link_address); end
    checks++; if ({taken, mispredict, misaligned, illegal} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {taken, mispredict, misaligned, illegal}); end
    for (int i = 0; i < 16; i++) begin
      predict_pc = 32'(i * 4);
      #1;
      checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL reset_bht[%0d] got %0b want 0", i, predict_taken); end
    end
    $display("test_reset done");
  endtask

  task automatic test_beq();
    set_br(2'b00, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0);
    tick();
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL beq_valid got %0b want 1", out_valid); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %0b want 1", taken); end
    checks++; if (new_program_counter !== 32'h120) begin errors++; $display("FAIL beq_npc got %h want 120", new_program_counter); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict got %0b want 1", mispredict); end
    checks++; if (link_address !== 32'h104) begin errors++; $display("FAIL beq_link got %h want 104", link_address); end
    checks++; if ({misaligned, illegal} !== 2'b00) begin errors++; $display("FAIL beq_flags got %b want 00", {misaligned, illegal}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_valid_drop got %0b want 0", out_valid); end
    checks++; if (new_program_counter !== 32'h120) begin errors++; $display("FAIL beq_npc_hold got %h want 120", new_program_counter); end
    $display("test_beq done");
  endtask

  task automatic test_compare();
    set_br(2'b00, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h204, 32'h8, 1'b1);  // BLT
    tick();
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL blt_taken got %0b want 1", taken); end
    checks++; if (new_program_counter !== 32'h20C) begin errors++; $display("FAIL blt_npc got %h want 20c", new_program_counter); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL blt_mispredict got %0b want 0", mispredict); end
    funct3 = 3'b110;  // BLTU
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bltu_valid got %0b want 1", out_valid); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bltu_taken got %0b want 0", taken); end
    checks++; if (new_program_counter !== 32'h208) begin errors++; $display("FAIL bltu_npc got %h want 208", new_program_counter); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL bltu_mispredict got %0b want 1", mispredict); end
    funct3 = 3'b101;  // BGE
    tick();
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bge_taken got %0b want 0", taken); end
    funct3 = 3'b111;  // BGEU
    tick();
    idle();
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bgeu_taken got %0b want 1", taken); end
    checks++; if (new_program_counter !== 32'h20C) begin errors++; $display("FAIL bgeu_npc got %h want 20c", new_program_counter); end
    tick();
    $display("test_compare done");
  endtask

  task automatic test_bht_training();
    logic pre_exp [7];
    logic post_exp [7];
    pre_exp  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    post_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    predict_pc = 32'h40;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) set_br(2'b00, 3'b001, 32'h1, 32'h2, 32'h40, 32'h10, 1'b0);
      else       set_br(2'b00, 3'b001, 32'h3, 32'h3, 32'h40, 32'h10, 1'b0);
      #1;
      checks++; if (predict_taken !== pre_exp[i]) begin errors++; $display("FAIL bht_pre[%0d] got %0b want %0b", i, predict_taken, pre_exp[i]); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bht_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (new_program_counter !== (i < 3 ? 32'h50 : 32'h44)) begin errors++; $display("FAIL bht_npc[%0d] got %h", i, new_program_counter); end
      checks++; if (predict_taken !== post_exp[i]) begin errors++; $display("FAIL bht_post[%0d] got %0b want %0b", i, predict_taken, post_exp[i]); end
    end
    idle();
    predict_pc = 32'h44;
    #1;
    checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL bht_neighbor got %0b want 0", predict_taken); end
    tick();
    $display("test_bht_training done");
  endtask

  task automatic test_jumps();
    set_br(2'b10, 3'b000, 32'h1003, 32'h0, 32'h300, 32'h0, 1'b1);  // JALR
    tick();
    checks++; if (new_program_counter !== 32'h1002) begin errors++; $display("FAIL jalr_npc got %h want 1002", new_program_counter); end
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL jalr_misaligned got %0b want 1", misaligned); end
    checks++; if (link_address !== 32'h304) begin errors++; $display("FAIL jalr_link got %h want 304", link_address); end
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL jalr_mispredict got %0b want 1", mispredict); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jalr_taken got %0b want 1", taken); end
    set_br(2'b01, 3'b000, 32'h0, 32'h0, 32'h300, 32'h100, 1'b1);  // JAL
    tick();
    idle();
    checks++; if (new_program_counter !== 32'h400) begin errors++; $display("FAIL jal_npc got %h want 400", new_program_counter); end
    checks++; if ({taken, mispredict, misaligned} !== 3'b100) begin errors++; $display("FAIL jal_flags got %b want 100", {taken, mispredict, misaligned}); end
    tick();
    $display("test_jumps done");
  endtask

  task automatic test_illegal_and_none();
    set_br(2'b00, 3'b010, 32'h7, 32'h7, 32'h48, 32'h20, 1'b1);
    tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got %0b want 1", illegal); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL illegal_taken got %0b want 0", taken); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL illegal_mispredict got %0b want 0", mispredict); end
    checks++; if (new_program_counter !== 32'h4C) begin errors++; $display("FAIL illegal_npc got %h want 4c", new_program_counter); end
    set_br(2'b11, 3'b000, 32'h7, 32'h7, 32'h4C, 32'h20, 1'b1);  // kind none
    tick();
    checks++; if ({taken, mispredict, illegal} !== 3'b010) begin errors++; $display("FAIL none_flags got %b want 010", {taken, mispredict, illegal}); end
    checks++; if (new_program_counter !== 32'h50) begin errors++; $display("FAIL none_npc got %h want 50", new_program_counter); end
    // An untouched counter (01) reaches 10 after one taken branch; a wrongly trained one stays below.
    set_br(2'b00, 3'b000, 32'h1, 32'h1, 32'h48, 32'h8, 1'b0);
    tick();
    set_br(2'b00, 3'b000, 32'h1, 32'h1, 32'h4C, 32'h8, 1'b0);
    tick();
    idle();
    predict_pc = 32'h48;
    #1;
    checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL illegal_no_train got %0b want 1", predict_taken); end
    predict_pc = 32'h4C;
    #1;
    checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL none_no_train got %0b want 1", predict_taken); end
    tick();
    $display("test_illegal_and_none done");
  endtask

  task automatic test_flush();
    set_br(2'b01, 3'b000, 32'h0, 32'h0, 32'h500, 32'h10, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %0b want 1", out_valid); end
    set_br(2'b00, 3'b000, 32'h9, 32'h9, 32'h40, 32'h20, 1'b0);
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid[%0d] got %0b want 0", i, out_valid); end
      checks++; if (new_program_counter !== 32'h510) begin errors++; $display("FAIL flush_npc_hold[%0d] got %h want 510", i, new_program_counter); end
    end
    flush = 1'b0;
    predict_pc = 32'h40;
    tick();  // real taken BEQ: counter 00 -> 01
    idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_after_valid got %0b want 1", out_valid); end
    checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL flush_bht got %0b want 0", predict_taken); end
    tick();
    $display("test_flush done");
  endtask

  task automatic test_reset_during_valid();
    set_br(2'b00, 3'b000, 32'h1, 32'h1, 32'h40, 32'h20, 1'b0);
    predict_pc = 32'h40;
    tick(); tick();  // 01 -> 10 -> 11
    checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL rst_pre_bht got %0b want 1", predict_taken); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++; if (new_program_counter !== 32'h0) begin errors++; $display("FAIL rst_npc got %h want 0", new_program_counter); end
    checks++; if (link_address !== 32'h0) begin errors++; $display("FAIL rst_link got %h want 0", link_address); end
    checks++; if ({taken, mispredict, misaligned, illegal} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {taken, mispredict, misaligned, illegal}); end
    checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL rst_bht got %0b want 0", predict_taken); end
    tick();
    $display("test_reset_during_valid done");
  endtask

  initial begin
    reset = 1'b1; is_compressed = 1'b0; predict_pc = '0;
    rs1 = '0; rs2 = '0; pc = '0; offset = '0; funct3 = '0; predicted_taken = 1'b0;
    idle();
    #1;
    test_reset();
    test_beq();
    test_compare();
    test_bht_training();
    test_jumps();
    test_illegal_and_none();
    test_flush();
    test_reset_during_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
